// File: rtl/step1_0.sv
// -----------------------------------------------------------------------------
// step1_0 -- second-stage radix-2 single-delay-feedback butterfly
//
// Takes one LANES-wide complex vector per accepted beat. Within each group of
// 2*D vectors, vectors D apart are paired: the second half of the group emits
// a+b immediately and parks a-b in the delay line. The parked differences are
// emitted while the next group's first half is being stored, or by a D-cycle
// flush after the frame's last beat. Odd groups rotate the difference by -j.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   din_valid  input vector valid this cycle
//   din_r/i    input vector, LANES signed samples of DW bits
//   valid_out  output vector valid (registered)
//   dout_r/i   output vector, LANES signed samples of DW+1 bits (registered)
//   err_drop   one-cycle pulse: an input beat arrived mid-flush and was dropped
// -----------------------------------------------------------------------------
module step1_0 #(
    parameter int DW        = 13,
    parameter int LANES     = 16,
    parameter int D         = 2,
    parameter int FRAME_VEC = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     din_valid,
    input  logic [LANES-1:0][DW-1:0] din_r,
    input  logic [LANES-1:0][DW-1:0] din_i,
    output logic                     valid_out,
    output logic [LANES-1:0][DW:0]   dout_r,
    output logic [LANES-1:0][DW:0]   dout_i,
    output logic                     err_drop
);
    localparam int IW = (FRAME_VEC > 2) ? $clog2(FRAME_VEC) : 1;
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_VEC - 1);
    localparam logic [PW-1:0] LAST_POS = PW'(D - 1);

    typedef enum logic [1:0] {IDLE, FILL, PAIR, FLUSH} state_t;

    // State entered after a frame's beat 0 (only D=1 makes beat 1 a pair beat)
    localparam state_t AFTER_FIRST = (D == 1) ? PAIR : FILL;

    state_t        state;
    logic [IW-1:0] vec_idx;
    logic [PW-1:0] flush_pos;
    logic          pending;     // delay line holds differences not yet emitted

    logic [LANES-1:0][DW:0] delay_r [D];
    logic [LANES-1:0][DW:0] delay_i [D];

    logic [IW-1:0] idx_next;
    logic [PW-1:0] beat_pos;
    logic [PW-1:0] rd_pos;
    logic          beat_pair;
    logic          beat_odd;
    logic          next_pair;

    logic [LANES-1:0][DW:0] a_r, a_i;
    logic [LANES-1:0][DW:0] ext_r, ext_i;
    logic [LANES-1:0][DW:0] sum_r, sum_i;
    logic [LANES-1:0][DW:0] dif_r, dif_i;

    // vec_idx is 0 in IDLE and FLUSH, so a beat taken there decodes as beat 0.
    always_comb begin
        idx_next  = vec_idx + 1'b1;
        beat_pos  = PW'(int'(vec_idx) % D);
        beat_pair = ((int'(vec_idx) / D) % 2) == 1;
        beat_odd  = ((int'(vec_idx) / (2 * D)) % 2) == 1;
        next_pair = ((int'(idx_next) / D) % 2) == 1;
        rd_pos    = (state == FLUSH) ? flush_pos : beat_pos;
    end

    // Per-lane butterfly. Operands are carried at DW+1 bits, so the symmetric
    // range of the difference makes the -j negation overflow-free.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DW:0] dr;
        logic [DW:0] di;

        assign ext_r[gi] = {din_r[gi][DW-1], din_r[gi]};
        assign ext_i[gi] = {din_i[gi][DW-1], din_i[gi]};
        assign a_r[gi]   = delay_r[rd_pos][gi];
        assign a_i[gi]   = delay_i[rd_pos][gi];
        assign sum_r[gi] = a_r[gi] + ext_r[gi];
        assign sum_i[gi] = a_i[gi] + ext_i[gi];
        assign dr        = a_r[gi] - ext_r[gi];
        assign di        = a_i[gi] - ext_i[gi];
        // -j * (dr + j*di) = di - j*dr
        assign dif_r[gi] = beat_odd ? di  : dr;
        assign dif_i[gi] = beat_odd ? -dr : di;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            vec_idx   <= '0;
            flush_pos <= '0;
            pending   <= 1'b0;
            valid_out <= 1'b0;
            dout_r    <= '0;
            dout_i    <= '0;
            err_drop  <= 1'b0;
            for (int k = 0; k < D; k++) begin
                delay_r[k] <= '0;
                delay_i[k] <= '0;
            end
        end else begin
            valid_out <= 1'b0;
            err_drop  <= 1'b0;
            case (state)
                IDLE, FILL, PAIR: begin
                    if (din_valid) begin
                        if (beat_pair) begin
                            valid_out       <= 1'b1;
                            dout_r          <= sum_r;
                            dout_i          <= sum_i;
                            delay_r[rd_pos] <= dif_r;
                            delay_i[rd_pos] <= dif_i;
                            pending         <= 1'b1;
                        end else begin
                            if (pending) begin
                                valid_out <= 1'b1;
                                dout_r    <= a_r;
                                dout_i    <= a_i;
                            end
                            delay_r[rd_pos] <= ext_r;
                            delay_i[rd_pos] <= ext_i;
                        end
                        if (vec_idx == LAST_IDX) begin
                            state     <= FLUSH;
                            vec_idx   <= '0;
                            flush_pos <= '0;
                        end else begin
                            vec_idx <= idx_next;
                            state   <= next_pair ? PAIR : FILL;
                        end
                    end
                end
                FLUSH: begin
                    valid_out <= 1'b1;
                    dout_r    <= a_r;
                    dout_i    <= a_i;
                    if (din_valid && flush_pos == '0) begin
                        // Back-to-back frame: this beat is beat 0 of the next
                        // frame; the remaining diffs drain through its FILL beats.
                        delay_r[rd_pos] <= ext_r;
                        delay_i[rd_pos] <= ext_i;
                        vec_idx         <= IW'(1);
                        state           <= AFTER_FIRST;
                    end else begin
                        if (din_valid) begin
                            err_drop <= 1'b1;
                        end
                        if (flush_pos == LAST_POS) begin
                            state     <= IDLE;
                            flush_pos <= '0;
                            pending   <= 1'b0;
                        end else begin
                            flush_pos <= flush_pos + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step1_0.sv
`timescale 1ns/1ps
module tb_step1_0;
    localparam int DW    = 13;
    localparam int LANES = 16;
    localparam int D     = 2;
    localparam int FV    = 32;

    typedef logic [LANES-1:0][DW-1:0] vin_t;
    typedef logic [LANES-1:0][DW:0]   vout_t;

    logic  clk = 1'b0;
    logic  rstn;
    logic  din_valid;
    vin_t  din_r, din_i;
    logic  valid_out;
    vout_t dout_r, dout_i;
    logic  err_drop;

    step1_0 #(.DW(DW), .LANES(LANES), .D(D), .FRAME_VEC(FV)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_valid (din_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .valid_out (valid_out),
        .dout_r    (dout_r),
        .dout_i    (dout_i),
        .err_drop  (err_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    vin_t  vec_r [FV];
    vin_t  vec_i [FV];
    int    plan [$];          // per cycle: vector index, -1 idle, -2 junk beat
    vout_t exp_r [$];
    vout_t exp_i [$];
    bit    exp_v [$];
    bit    exp_e [$];
    logic signed [DW:0] cap_r [$];
    logic signed [DW:0] cap_i [$];

    int ramp_r [8] = '{2, 4, -2, -2, 10, 12, 0, 0};
    int ramp_i [8] = '{0, 0, 0, 0, 0, 0, 2, 2};
    int xtr_r  [8] = '{-1, -1, 8191, -8191, -1, 0, 0, 8191};
    int xtr_i  [8] = '{0, 0, 0, 0, 0, -1, 8191, 0};

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    // Reference butterfly over one frame held in vec_r/vec_i: per group,
    // D sums followed by D (possibly -j rotated) differences.
    task automatic push_frame();
        vout_t wr, wi;
        int ar, ai, br, bi, dr, di, va, vb;
        for (int g = 0; g < FV / (2 * D); g++) begin
            for (int j = 0; j < D; j++) begin
                va = 2 * D * g + j;
                vb = va + D;
                for (int l = 0; l < LANES; l++) begin
                    wr[l] = (DW+1)'(sx(vec_r[va][l]) + sx(vec_r[vb][l]));
                    wi[l] = (DW+1)'(sx(vec_i[va][l]) + sx(vec_i[vb][l]));
                end
                exp_r.push_back(wr);
                exp_i.push_back(wi);
            end
            for (int j = 0; j < D; j++) begin
                va = 2 * D * g + j;
                vb = va + D;
                for (int l = 0; l < LANES; l++) begin
                    ar = sx(vec_r[va][l]); ai = sx(vec_i[va][l]);
                    br = sx(vec_r[vb][l]); bi = sx(vec_i[vb][l]);
                    dr = ar - br;
                    di = ai - bi;
                    if (g % 2 == 1) begin
                        wr[l] = (DW+1)'(di);
                        wi[l] = (DW+1)'(-dr);
                    end else begin
                        wr[l] = (DW+1)'(dr);
                        wi[l] = (DW+1)'(di);
                    end
                end
                exp_r.push_back(wr);
                exp_i.push_back(wi);
            end
        end
    endtask

    task automatic build_ramp();
        for (int k = 0; k < FV; k++)
            for (int l = 0; l < LANES; l++) begin
                vec_r[k][l] = DW'(k);
                vec_i[k][l] = '0;
            end
    endtask

    task automatic build_random();
        for (int k = 0; k < FV; k++)
            for (int l = 0; l < LANES; l++) begin
                vec_r[k][l] = DW'($urandom());
                vec_i[k][l] = DW'($urandom());
            end
    endtask

    task automatic plan_frame();
        for (int k = 0; k < FV; k++) plan.push_back(k);
    endtask

    // Expected valid_out windows [v0,v1] and [v2,v3]; err_drop expected at cycle e.
    task automatic set_window(input int n, input int v0, input int v1,
                              input int v2, input int v3, input int e);
        exp_v.delete();
        exp_e.delete();
        for (int t = 0; t < n; t++) begin
            exp_v.push_back((t >= v0 && t <= v1) || (t >= v2 && t <= v3));
            exp_e.push_back(t == e);
        end
    endtask

    // Drives the plan and, in parallel, scores every cycle of DUT output.
    task automatic run_stream(input string name, input int n);
        vout_t wr, wi;
        cap_r.delete();
        cap_i.delete();
        fork
            begin
                for (int p = 0; p < n; p++) begin
                    @(negedge clk);
                    if (p < plan.size() && plan[p] >= 0) begin
                        din_valid = 1'b1;
                        din_r     = vec_r[plan[p]];
                        din_i     = vec_i[plan[p]];
                    end else if (p < plan.size() && plan[p] == -2) begin
                        din_valid = 1'b1;
                        for (int l = 0; l < LANES; l++) begin
                            din_r[l] = DW'(1234);
                            din_i[l] = DW'(-777);
                        end
                    end else begin
                        din_valid = 1'b0;
                    end
                end
            end
            begin
                for (int c = 0; c < n; c++) begin
                    @(negedge clk);
                    total++;
                    if (valid_out !== exp_v[c]) begin
                        bad++;
                        $display("FAIL %s valid_out c=%0d got=%b want=%b", name, c, valid_out, exp_v[c]);
                    end
                    total++;
                    if (err_drop !== exp_e[c]) begin
                        bad++;
                        $display("FAIL %s err_drop c=%0d got=%b want=%b", name, c, err_drop, exp_e[c]);
                    end
                    if (valid_out === 1'b1) begin
                        total++;
                        if (exp_r.size() == 0) begin
                            bad++;
                            $display("FAIL %s extra output c=%0d got_r0=%0d want=none", name, c, $signed(dout_r[0]));
                        end else begin
                            wr = exp_r.pop_front();
                            wi = exp_i.pop_front();
                            $display("%s c=%0d r0=%0d i0=%0d", name, c, $signed(dout_r[0]), $signed(dout_i[0]));
                            if (dout_r !== wr || dout_i !== wi) begin
                                bad++;
                                $display("FAIL %s data c=%0d got_r=%h want_r=%h got_i=%h want_i=%h",
                                         name, c, dout_r, wr, dout_i, wi);
                            end
                        end
                        cap_r.push_back($signed(dout_r[0]));
                        cap_i.push_back($signed(dout_i[0]));
                    end
                end
            end
        join
        din_valid = 1'b0;
        total++;
        if (exp_r.size() != 0) begin
            bad++;
            $display("FAIL %s missing outputs got=0 want=%0d more", name, exp_r.size());
        end
        exp_r.delete();
        exp_i.delete();
        plan.delete();
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        din_valid = 1'b0;
        din_r     = '0;
        din_i     = '0;
        repeat (3) @(negedge clk);
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL reset valid_out got=%b want=0", valid_out); end
        total++;
        if (dout_r !== '0) begin bad++; $display("FAIL reset dout_r got=%h want=0", dout_r); end
        total++;
        if (dout_i !== '0) begin bad++; $display("FAIL reset dout_i got=%h want=0", dout_i); end
        total++;
        if (err_drop !== 1'b0) begin bad++; $display("FAIL reset err_drop got=%b want=0", err_drop); end
        $display("reset checked");
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_ramp_literals(input string name);
        total++;
        if (cap_r.size() < 8) begin
            bad++;
            $display("FAIL %s ramp capture got=%0d want=8 outputs", name, cap_r.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (cap_r[k] !== (DW+1)'(ramp_r[k]) || cap_i[k] !== (DW+1)'(ramp_i[k])) begin
                    bad++;
                    $display("FAIL %s ramp out%0d got=(%0d,%0d) want=(%0d,%0d)",
                             name, k, cap_r[k], cap_i[k], ramp_r[k], ramp_i[k]);
                end
            end
        end
    endtask

    task automatic test_contiguous();
        build_ramp();
        plan_frame();
        push_frame();
        set_window(40, D + 1, D + FV, 1, 0, -1);
        run_stream("contig", 40);
        check_ramp_literals("contig");
    endtask

    task automatic test_extremes();
        for (int k = 0; k < FV; k++) begin
            vec_r[k] = '0;
            vec_i[k] = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            vec_r[0][l] = DW'(4095);
            vec_r[2][l] = DW'(-4096);
            vec_r[1][l] = DW'(-4096);
            vec_r[3][l] = DW'(4095);
            vec_r[4][l] = DW'(-4096);
            vec_r[6][l] = DW'(4095);
            vec_i[5][l] = DW'(4095);
            vec_i[7][l] = DW'(-4096);
        end
        plan_frame();
        push_frame();
        set_window(40, D + 1, D + FV, 1, 0, -1);
        run_stream("extreme", 40);
        total++;
        if (cap_r.size() < 8) begin
            bad++;
            $display("FAIL extreme capture got=%0d want=8 outputs", cap_r.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (cap_r[k] !== (DW+1)'(xtr_r[k]) || cap_i[k] !== (DW+1)'(xtr_i[k])) begin
                    bad++;
                    $display("FAIL extreme out%0d got=(%0d,%0d) want=(%0d,%0d)",
                             k, cap_r[k], cap_i[k], xtr_r[k], xtr_i[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        build_random();
        plan_frame();
        plan_frame();
        push_frame();
        push_frame();
        set_window(72, D + 1, D + 2 * FV, 1, 0, -1);
        run_stream("b2b", 72);
    endtask

    task automatic test_stall();
        build_random();
        for (int k = 0; k < 10; k++) plan.push_back(k);
        for (int k = 0; k < 5; k++) plan.push_back(-1);
        for (int k = 10; k < FV; k++) plan.push_back(k);
        push_frame();
        // beat 9 lands on edge 9; outputs stop for exactly 5 cycles after it
        set_window(45, D + 1, 10, 16, D + FV + 5, -1);
        run_stream("stall", 45);
    endtask

    task automatic test_illegal_start();
        build_random();
        plan_frame();
        plan.push_back(-1);
        plan.push_back(-2);       // arrives at flush pos 1
        plan_frame();             // first beat arrives with the block back in IDLE
        push_frame();
        push_frame();
        set_window(74, D + 1, D + FV, FV + 2 + D + 1, FV + 2 + D + FV, FV + 2);
        run_stream("illegal", 74);
    endtask

    task automatic test_reset_mid();
        build_ramp();
        for (int b = 0; b < 14; b++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din_r     = vec_r[b];
            din_i     = vec_i[b];
        end
        @(negedge clk);
        din_valid = 1'b0;
        // beat 13 is a first-half beat of group 3 and emits a pending difference
        total++;
        if (valid_out !== 1'b1) begin bad++; $display("FAIL midreset pre valid_out got=%b want=1", valid_out); end
        rstn = 1'b0;
        #1;
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL midreset valid_out got=%b want=0", valid_out); end
        total++;
        if (dout_r !== '0 || dout_i !== '0) begin
            bad++;
            $display("FAIL midreset dout got_r=%h got_i=%h want=0", dout_r, dout_i);
        end
        $display("midreset checked");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        plan_frame();
        push_frame();
        set_window(40, D + 1, D + FV, 1, 0, -1);
        run_stream("after_reset", 40);
        check_ramp_literals("after_reset");
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_extremes();
        test_back_to_back();
        test_stall();
        test_illegal_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
